int_service: RTL and testbench

INT_SERVICE -- requirements
Module: int_service

---
 rtl/int_service_pkg.sv | 41 ++++
 rtl/int_prio_enc8.sv | 31 +++
 rtl/int_service.sv | 188 ++++++++++++++++++
 tb/tb_int_service.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/int_service_pkg.sv
// -----------------------------------------------------------------------------
// int_service_pkg
// Shared interrupt package: constants describing the interrupt block's
// register interface, default timing for the interrupt service controller,
// FSM state encodings and small saturating-increment helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package int_service_pkg;

  // Interrupt block register interface
  localparam int INT_REG_W = 8;
  localparam int INT_IDX_W = 3;
  // intreg is active-low: all ones means nothing has changed
  localparam logic [INT_REG_W-1:0] INT_REG_NONE_PENDING = 8'hFF;

  // Service controller timing defaults (legal range 1..15)
  localparam int INT_READ_CYCLES_DEF  = 2;
  localparam int INT_BLANK_CYCLES_DEF = 4;
  localparam int INT_TMR_W            = 4;

  // Service controller state encodings
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_READ     = 2'd1;
  localparam logic [1:0] ST_DISPATCH = 2'd2;
  localparam logic [1:0] ST_BLANK    = 2'd3;

  // Event presented to the consumer
  typedef struct packed {
    logic [INT_IDX_W-1:0] idx;
    logic                 last;
  } int_evt_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/int_prio_enc8.sv
// -----------------------------------------------------------------------------
// int_prio_enc8
// Lowest-set-bit priority encoder, 8 -> 3, plus a flag telling whether the
// vector holds exactly one set bit. Purely combinational.
// Ports:
//   i_vec      - input vector (pending bits)
//   o_idx      - index of the lowest set bit (0 when i_vec is zero)
//   o_one_left - 1 when exactly one bit of i_vec is set
// -----------------------------------------------------------------------------
module int_prio_enc8
  import int_service_pkg::*;
(
  input  logic [INT_REG_W-1:0] i_vec,
  output logic [INT_IDX_W-1:0] o_idx,
  output logic                 o_one_left
);

  // Scan from the top down so the lowest set bit wins last.
  always_comb begin
    o_idx = '0;
    for (int i = INT_REG_W - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = INT_IDX_W'(i);
    end
  end

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  always_comb begin
    o_one_left = (i_vec != '0) && ((i_vec & (i_vec - 8'd1)) == '0);
  end

endmodule

// File: rtl/int_service.sv
// -----------------------------------------------------------------------------
// int_service
// Interrupt service controller. On an unmasked interrupt request it strobes
// reading_int for READ_CYCLES cycles, captures the active-low pending
// register on the last strobe cycle, then hands the pending bits to a
// consumer one at a time (lowest index first) over a valid/ready channel.
// After each read a BLANK_CYCLES window ignores int_bit so the interrupt
// block can drop its request.
//
// Ports:
//   clk            - clock, rising edge
//   rst_n          - asynchronous active-low reset
//   int_bit        - interrupt request from the interrupt block
//   intreg[7:0]    - pending-change register, 0 = change pending
//   mask_en        - software mask, 1 = do not start new reads
//   reading_int    - registered read strobe to the interrupt block
//   int_mask       - mask_en delayed one cycle, to the interrupt block
//   evt_valid      - event available
//   evt_ready      - consumer accepts event
//   evt_idx[2:0]   - bit index of the presented event
//   evt_last       - presented event is the last one from this read
//   evt_count[15:0]     - accepted events, saturating
//   spurious_count[7:0] - reads that found nothing pending, saturating
//
// State table
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | waiting for int_bit with mask_en low
//   READ      | reading_int high; capture ~intreg on the final cycle
//   DISPATCH  | presenting pending bits lowest-first to the consumer
//   BLANK     | int_bit ignored for BLANK_CYCLES, then back to IDLE
// -----------------------------------------------------------------------------
module int_service
  import int_service_pkg::*;
#(
  parameter int READ_CYCLES  = INT_READ_CYCLES_DEF,
  parameter int BLANK_CYCLES = INT_BLANK_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 int_bit,
  input  logic [INT_REG_W-1:0] intreg,
  input  logic                 mask_en,
  output logic                 reading_int,
  output logic                 int_mask,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [INT_IDX_W-1:0] evt_idx,
  output logic                 evt_last,
  output logic [15:0]          evt_count,
  output logic [7:0]           spurious_count
);

  // Timers are down-counters loaded with N-1; the cycle on which they read
  // zero is the Nth and final cycle of the phase.
  localparam logic [INT_TMR_W-1:0] READ_TC_LOAD  = INT_TMR_W'(READ_CYCLES - 1);
  localparam logic [INT_TMR_W-1:0] BLANK_TC_LOAD = INT_TMR_W'(BLANK_CYCLES - 1);

  logic [1:0]           r_state;
  logic [INT_TMR_W-1:0] r_tmr;
  logic [INT_REG_W-1:0] r_pending;
  logic                 r_reading;
  logic                 r_mask;
  logic [15:0]          r_evt_cnt;
  logic [7:0]           r_spur_cnt;

  logic [INT_IDX_W-1:0] w_idx;
  logic                 w_one_left;
  int_evt_t             w_evt;
  logic [INT_REG_W-1:0] w_capture;
  logic [INT_REG_W-1:0] w_idx_bit;
  logic                 w_tmr_done;
  logic                 w_start;
  logic                 w_nothing_pending;
  logic                 w_handshake;

  int_prio_enc8 u_prio_enc (
    .i_vec      (r_pending),
    .o_idx      (w_idx),
    .o_one_left (w_one_left)
  );

  assign w_evt             = '{idx: w_idx, last: w_one_left};
  assign w_capture         = ~intreg;
  assign w_nothing_pending = (intreg == INT_REG_NONE_PENDING);
  assign w_idx_bit         = INT_REG_W'(1) << w_idx;
  assign w_tmr_done        = (r_tmr == '0);
  assign w_start           = int_bit && !mask_en;
  assign w_handshake       = (r_state == ST_DISPATCH) && evt_ready;

  // FSM, timer and pending vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_tmr     <= '0;
      r_pending <= '0;
      r_reading <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state   <= ST_READ;
            r_reading <= 1'b1;
            r_tmr     <= READ_TC_LOAD;
          end
        end

        ST_READ: begin
          // mask_en is deliberately not looked at here: a started read completes.
          if (w_tmr_done) begin
            r_reading <= 1'b0;
            r_pending <= w_capture;
            if (w_nothing_pending) begin
              r_state <= ST_BLANK;
              r_tmr   <= BLANK_TC_LOAD;
            end else begin
              r_state <= ST_DISPATCH;
            end
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end

        ST_DISPATCH: begin
          if (w_handshake) begin
            r_pending <= r_pending & ~w_idx_bit;
            if (w_evt.last) begin
              r_state <= ST_BLANK;
              r_tmr   <= BLANK_TC_LOAD;
            end
          end
        end

        ST_BLANK: begin
          if (w_tmr_done) begin
            r_state <= ST_IDLE;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_tmr     <= '0;
          r_pending <= '0;
          r_reading <= 1'b0;
        end
      endcase
    end
  end

  // Statistics counters; each has its own increment condition so they
  // never interfere with one another.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_cnt <= '0;
    end else if (w_handshake) begin
      r_evt_cnt <= sat_inc16(r_evt_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spur_cnt <= '0;
    end else if ((r_state == ST_READ) && w_tmr_done && w_nothing_pending) begin
      r_spur_cnt <= sat_inc8(r_spur_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= 1'b0;
    end else begin
      r_mask <= mask_en;
    end
  end

  // r_pending is zero outside DISPATCH, so idx/last fall to 0 there and
  // follow reset asynchronously along with evt_valid.
  assign evt_valid      = (r_state == ST_DISPATCH);
  assign evt_idx        = w_evt.idx;
  assign evt_last       = w_evt.last;
  assign reading_int    = r_reading;
  assign int_mask       = r_mask;
  assign evt_count      = r_evt_cnt;
  assign spurious_count = r_spur_cnt;

endmodule

// File: tb/tb_int_service.sv
module tb_int_service;

  localparam int RC = 2;
  localparam int BC = 4;

  logic        clk;
  logic        rst_n;
  logic        int_bit;
  logic [7:0]  intreg;
  logic        mask_en;
  logic        reading_int;
  logic        int_mask;
  logic        evt_valid;
  logic        evt_ready;
  logic [2:0]  evt_idx;
  logic        evt_last;
  logic [15:0] evt_count;
  logic [7:0]  spurious_count;

  logic [30:0] outs;
  assign outs = {reading_int, int_mask, evt_valid, evt_idx, evt_last, evt_count, spurious_count};

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard queues: expected read-strobe lengths and expected {last, idx}
  int         rd_q[$];
  logic [3:0] evt_q[$];

  int_service dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .int_bit        (int_bit),
    .intreg         (intreg),
    .mask_en        (mask_en),
    .reading_int    (reading_int),
    .int_mask       (int_mask),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_idx        (evt_idx),
    .evt_last       (evt_last),
    .evt_count      (evt_count),
    .spurious_count (spurious_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_cnt(input logic [15:0] target, input string name);
    int t = 0;
    while (evt_count != target && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(name, evt_count, target);
  endtask

  task automatic wait_valid(input string name);
    int t = 0;
    while (!evt_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(name, evt_valid, 1);
  endtask

  // Monitor: read-strobe length and event stream checked against the queues
  int run = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else begin
      if (reading_int) begin
        run++;
      end else if (run != 0) begin
        if (rd_q.size() == 0) chk("read_unexpected", run, 0);
        else                  chk("read_len", run, rd_q.pop_front());
        run = 0;
      end
      if (evt_valid && evt_q.size() != 0)
        chk("evt_present", {evt_last, evt_idx}, evt_q[0]);
      if (evt_valid && evt_ready) begin
        if (evt_q.size() == 0) chk("evt_unexpected", evt_q.size(), 1);
        else                   chk("evt_accept", {evt_last, evt_idx}, evt_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int gap;
    int cnt;
    int hi;
    rst_n = 1'b0; int_bit = 1'b0; intreg = 8'hFF; mask_en = 1'b0; evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Quiet after reset release
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("reset_idle", outs, 0);
    end

    // F6 -> pending 09: idx 0 then 3 (last); int_bit held to measure blanking
    for (int r = 0; r < 2; r++) begin
      rd_q.push_back(RC);
      evt_q.push_back({1'b0, 3'd0});
      evt_q.push_back({1'b1, 3'd3});
    end
    @(posedge clk); #1 intreg = 8'hF6; int_bit = 1'b1; evt_ready = 1'b1;
    wait_cnt(16'd2, "t1_first_read");
    chk("t1_valid_after_last", evt_valid, 0);
    gap = 0;
    while (!reading_int && gap < 50) begin
      gap++;
      @(negedge clk);
    end
    chk("t1_blank_gap", gap, BC + 1);
    @(posedge clk); #1 int_bit = 1'b0;
    wait_cnt(16'd4, "t1_second_read");
    chk("t1_spurious", spurious_count, 0);

    // 00 -> all 8 pending, consumer stalls 5 cycles then streams
    repeat (8) @(negedge clk);
    rd_q.push_back(RC);
    for (int i = 0; i < 8; i++) evt_q.push_back({(i == 7), 3'(i)});
    @(posedge clk); #1 intreg = 8'h00; int_bit = 1'b1; evt_ready = 1'b0;
    @(posedge clk); #1 int_bit = 1'b0;
    wait_valid("t2_valid");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_hold", {evt_valid, evt_last, evt_idx}, {1'b1, 1'b0, 3'd0});
    end
    @(posedge clk); #1 evt_ready = 1'b1;
    cnt = 0;
    while (evt_count != 16'd12 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("t2_burst_cycles", cnt, 9);
    chk("t2_count", evt_count, 12);

    // FF -> spurious read
    repeat (8) @(negedge clk);
    rd_q.push_back(RC);
    @(posedge clk); #1 intreg = 8'hFF; int_bit = 1'b1;
    @(posedge clk); #1 int_bit = 1'b0;
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (evt_valid) hi++;
    end
    chk("t3_no_valid", hi, 0);
    chk("t3_spurious", spurious_count, 1);
    chk("t3_evt_count", evt_count, 12);

    // Mask blocks start; unmask starts read; re-mask mid-read does not abort
    repeat (4) @(negedge clk);
    @(posedge clk); #1 mask_en = 1'b1; intreg = 8'hFE; evt_ready = 1'b0;
    @(posedge clk); #1 int_bit = 1'b1;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (reading_int) hi++;
    end
    chk("t4_masked_no_read", hi, 0);
    chk("t4_int_mask_hi", int_mask, 1);
    rd_q.push_back(RC);
    evt_q.push_back({1'b1, 3'd0});
    @(posedge clk); #1 mask_en = 1'b0;
    @(negedge clk);
    chk("t4_int_mask_lag", int_mask, 1);
    chk("t4_no_read_yet", reading_int, 0);
    @(negedge clk);
    chk("t4_int_mask_lo", int_mask, 0);
    chk("t4_read_started", reading_int, 1);
    @(posedge clk); #1 mask_en = 1'b1; int_bit = 1'b0;
    wait_valid("t4_valid_despite_mask");
    @(posedge clk); #1 evt_ready = 1'b1;
    wait_cnt(16'd13, "t4_event");
    chk("t4_int_mask_follow", int_mask, 1);
    @(posedge clk); #1 mask_en = 1'b0;

    // Reset during DISPATCH of 7F pending
    repeat (8) @(negedge clk);
    rd_q.push_back(RC);
    @(posedge clk); #1 intreg = 8'h80; int_bit = 1'b1; evt_ready = 1'b0;
    @(posedge clk); #1 int_bit = 1'b0;
    wait_valid("t5_valid");
    chk("t5_first_evt", {evt_last, evt_idx}, {1'b0, 3'd0});
    #2 rst_n = 1'b0;
    #1 chk("t5_async_reset", outs, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t5_post_reset_quiet", outs, 0);
    end

    // A new read after reset works normally
    rd_q.push_back(RC);
    evt_q.push_back({1'b0, 3'd0});
    evt_q.push_back({1'b1, 3'd3});
    @(posedge clk); #1 intreg = 8'hF6; int_bit = 1'b1; evt_ready = 1'b1;
    @(posedge clk); #1 int_bit = 1'b0;
    wait_cnt(16'd2, "t6_recover");
    repeat (10) @(negedge clk);
    chk("evt_q_drained", evt_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
